dsp_subtractor: RTL and testbench

- Two-operand integer subtractor: out = input1 − input2 (mod 2^WIDTH).
- The data memory uses it to convert a word address into a data-block index by removing the instruction-memory offset (0x1000).
- The difference path is purely combinational, so the memory can use the result in the same cycle.
- Adds status flags and sticky, clocked exception bits for debug visibility.

---
 rtl/dsp_subtractor.sv | 75 +++++++
 tb/tb_dsp_subtractor.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/dsp_subtractor.sv
// Two-operand WIDTH-bit subtractor with status flags and sticky borrow/overflow bits.
// Optional macro DSP_SUB_PIPE_EN registers the result and flags (1-cycle latency).
module dsp_subtractor #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] input1,
    input  logic [WIDTH-1:0] input2,
    output logic [WIDTH-1:0] out,
    output logic             borrow,
    output logic             overflow,
    output logic             zero,
    output logic             negative,
    input  logic             sticky_clr,
    output logic             sticky_borrow,
    output logic             sticky_overflow
);

    // No handshake: operands are sampled continuously; there is no valid/ready pair.
    logic [WIDTH:0]   diff_full;
    logic [WIDTH-1:0] diff;
    logic             borrow_c;
    logic             overflow_c;
    logic             zero_c;
    logic             negative_c;

    always_comb begin
        diff_full  = {1'b0, input1} + {1'b0, ~input2} + {{WIDTH{1'b0}}, 1'b1};
        diff       = diff_full[WIDTH-1:0];
        // Carry-out of the two's-complement add is the inverse of the unsigned borrow.
        borrow_c   = ~diff_full[WIDTH];
        overflow_c = (input1[WIDTH-1] ^ input2[WIDTH-1]) & (diff[WIDTH-1] ^ input1[WIDTH-1]);
        zero_c     = (diff == '0);
        negative_c = diff[WIDTH-1];
    end

`ifdef DSP_SUB_PIPE_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            out      <= '0;
            borrow   <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
            negative <= 1'b0;
        end else begin
            out      <= diff;
            borrow   <= borrow_c;
            overflow <= overflow_c;
            zero     <= zero_c;
            negative <= negative_c;
        end
    end
`else
    always_comb begin
        out      = diff;
        borrow   = borrow_c;
        overflow = overflow_c;
        zero     = zero_c;
        negative = negative_c;
    end
`endif

    // Sticky bits watch the visible flags, so the pipelined build adds one more cycle.
    always_ff @(posedge clk) begin
        if (reset || sticky_clr) begin
            sticky_borrow   <= 1'b0;
            sticky_overflow <= 1'b0;
        end else begin
            sticky_borrow   <= sticky_borrow | borrow;
            sticky_overflow <= sticky_overflow | overflow;
        end
    end

endmodule

// File: tb/tb_dsp_subtractor.sv
// Directed bench for dsp_subtractor: flags, boundary vectors, sticky set/clear behaviour.
module tb_dsp_subtractor;

    localparam int WIDTH = 32;
`ifdef DSP_SUB_PIPE_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] input1;
    logic [WIDTH-1:0] input2;
    logic [WIDTH-1:0] out;
    logic             borrow;
    logic             overflow;
    logic             zero;
    logic             negative;
    logic             sticky_clr;
    logic             sticky_borrow;
    logic             sticky_overflow;

    int total = 0;
    int bad   = 0;
    logic [WIDTH-1:0] exp_q[$];

    dsp_subtractor #(.WIDTH(WIDTH)) dut (
        .clk             (clk),
        .reset           (reset),
        .input1          (input1),
        .input2          (input2),
        .out             (out),
        .borrow          (borrow),
        .overflow        (overflow),
        .zero            (zero),
        .negative        (negative),
        .sticky_clr      (sticky_clr),
        .sticky_borrow   (sticky_borrow),
        .sticky_overflow (sticky_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Apply operands and wait until the result is visible at the outputs.
    task automatic drive(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        input1 = a;
        input2 = b;
        if (LAT > 0) step();
        else #1;
    endtask

    task automatic check_flags(input string tag, input logic [WIDTH-1:0] e_out,
                               input logic e_b, input logic e_o, input logic e_z, input logic e_n);
        check({tag, ".out"}, out, e_out);
        check({tag, ".borrow"}, {31'd0, borrow}, {31'd0, e_b});
        check({tag, ".overflow"}, {31'd0, overflow}, {31'd0, e_o});
        check({tag, ".zero"}, {31'd0, zero}, {31'd0, e_z});
        check({tag, ".negative"}, {31'd0, negative}, {31'd0, e_n});
    endtask

    logic [WIDTH-1:0] vec_a [4] = '{32'h0000_0064, 32'hDEAD_BEEF, 32'h0000_1400, 32'hFFFF_FFFF};
    logic [WIDTH-1:0] vec_b [4] = '{32'h0000_0019, 32'h0000_0000, 32'h0000_1000, 32'h0000_0001};

    initial begin
        reset      = 1'b1;
        sticky_clr = 1'b0;
        input1     = '0;
        input2     = '0;
        step();
        reset = 1'b0;
        check("rst.sticky_borrow", {31'd0, sticky_borrow}, 32'd0);
        check("rst.sticky_overflow", {31'd0, sticky_overflow}, 32'd0);

        // Sticky set, hold and clear
        input1 = 32'd0;
        input2 = 32'd1;
        repeat (LAT + 1) step();
        check("stk.set", {31'd0, sticky_borrow}, 32'd1);
        input1 = 32'd5;
        input2 = 32'd3;
        repeat (LAT + 1) step();
        check("stk.hold", {31'd0, sticky_borrow}, 32'd1);
        sticky_clr = 1'b1;
        step();
        sticky_clr = 1'b0;
        check("stk.clr", {31'd0, sticky_borrow}, 32'd0);

        // Clear collides with a new borrow event: clear wins, event lands next edge
        sticky_clr = 1'b1;
        input1     = 32'd0;
        input2     = 32'd1;
        step();
        check("coll.clr_wins", {31'd0, sticky_borrow}, 32'd0);
        sticky_clr = 1'b0;
        step();
        check("coll.after", {31'd0, sticky_borrow}, 32'd1);
        sticky_clr = 1'b1;
        input1     = 32'd5;
        input2     = 32'd3;
        repeat (LAT + 1) step();
        sticky_clr = 1'b0;
        check("coll.reclr", {31'd0, sticky_borrow}, 32'd0);

        // Address-offset conversion
        drive(32'h0000_03FF, 32'h0000_1000);
        check_flags("addr", 32'hFFFF_F3FF, 1'b1, 1'b0, 1'b0, 1'b1);
        check("addr.low10", {22'd0, out[9:0]}, 32'h0000_03FF);

        // Equal operands
        drive(32'h1234_5678, 32'h1234_5678);
        check_flags("equal", 32'h0000_0000, 1'b0, 1'b0, 1'b1, 1'b0);

        // Zero minus one
        drive(32'h0000_0000, 32'h0000_0001);
        check_flags("zm1", 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b1);

        // Subtrahend zero
        drive(32'hA5A5_0F0F, 32'h0000_0000);
        check_flags("sub0", 32'hA5A5_0F0F, 1'b0, 1'b0, 1'b0, 1'b1);

        // Positive minus negative overflow
        drive(32'h7FFF_FFFF, 32'hFFFF_FFFF);
        check_flags("povf", 32'h8000_0000, 1'b1, 1'b1, 1'b0, 1'b1);

        // Signed overflow and its sticky capture
        sticky_clr = 1'b1;
        step();
        sticky_clr = 1'b0;
        check("ovf.pre_sticky", {31'd0, sticky_overflow}, 32'd0);
        drive(32'h8000_0000, 32'h0000_0001);
        check_flags("ovf", 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        check("ovf.sticky", {31'd0, sticky_overflow}, 32'd1);

        // Vector table through the expected queue
        exp_q.push_back(32'h0000_004B);
        exp_q.push_back(32'hDEAD_BEEF);
        exp_q.push_back(32'h0000_0400);
        exp_q.push_back(32'hFFFF_FFFE);
        for (int i = 0; i < 4; i++) begin
            drive(vec_a[i], vec_b[i]);
            check($sformatf("vec%0d.out", i), out, exp_q.pop_front());
        end

`ifdef DSP_SUB_PIPE_EN
        input1 = 32'h10;
        input2 = 32'h3;
        #1;
        check("pipe.before_edge", out, 32'hFFFF_FFFE);
        step();
        check("pipe.after_edge", out, 32'h0000_000D);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("pipe.reset_out", out, 32'h0000_0000);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
